// File: rtl/riscv_core_pkg.sv
// Shared core constants: reset PC, bubble encoding, next-PC select codes,
// fetch FSM states and the next-PC selection helper.
package riscv_core_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h1000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    localparam logic [1:0] PCSEL_JAL = 2'd0;
    localparam logic [1:0] PCSEL_ALU = 2'd1;
    localparam logic [1:0] PCSEL_PC4 = 2'd2;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Codes 2 and 3 both mean sequential fetch; the add wraps modulo 2^32.
    function automatic logic [31:0] select_pc(input logic [1:0]  sel,
                                              input logic [31:0] jal,
                                              input logic [31:0] alu,
                                              input logic [31:0] pc);
        logic [31:0] res;
        case (sel)
            PCSEL_JAL: res = jal;
            PCSEL_ALU: res = alu;
            default:   res = pc + 32'd4;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding pc, instruction and valid bit,
// with load, hold and kill (load the PC but insert a bubble).
module pipe_stage_reg
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        kill,
    input  logic [31:0] src_pc,
    input  logic [31:0] src_inst,
    input  logic        src_valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= 32'd0;
            inst  <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            // A killed slot keeps its PC so the bubble stays traceable.
            pc    <= src_pc;
            inst  <= kill ? NOP : src_inst;
            valid <= kill ? 1'b0 : src_valid;
        end
    end

endmodule

// File: rtl/fetch_pipe.sv
// Three-stage (FD / X / MW) fetch pipeline front end with a synchronous-read
// instruction BRAM, redirect handling, stall and retired-instruction counter.
module fetch_pipe
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jal_target,
    input  logic [31:0] alu_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] pc_fd,
    output logic [31:0] inst_fd,
    output logic [31:0] pc_x,
    output logic [31:0] inst_x,
    output logic [31:0] pc_mw,
    output logic [31:0] inst_mw,
    output logic [31:0] instret
);

    fetch_state_t state;
    logic         run;
    logic         fd_valid;
    logic         x_valid;
    logic         mw_valid;
    logic         advance;
    logic         kill_x;
    logic [31:0]  next_pc;

    assign run     = (state == RUN);
    assign next_pc = select_pc(pc_sel, jal_target, alu_target, pc_fd);
    // BOOT always steps forward; stall only freezes the pipe once running.
    assign advance = !run || !stall;
    assign kill_x  = run && (pc_sel == PCSEL_ALU);

    always_comb begin
        imem_addr = RESET_PC;
        inst_fd   = NOP;
        fd_valid  = 1'b0;
        if (!rst && run) begin
            imem_addr = stall ? pc_fd : next_pc;
            inst_fd   = imem_dout;
            fd_valid  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc_fd   <= RESET_PC;
            instret <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    pc_fd <= RESET_PC;
                end
                RUN: begin
                    if (!stall) begin
                        pc_fd <= next_pc;
                        if (mw_valid) begin
                            instret <= instret + 32'd1;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    pipe_stage_reg #(.NOP(NOP)) u_x (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .kill      (kill_x),
        .src_pc    (pc_fd),
        .src_inst  (inst_fd),
        .src_valid (fd_valid),
        .pc        (pc_x),
        .inst      (inst_x),
        .valid     (x_valid)
    );

    pipe_stage_reg #(.NOP(NOP)) u_mw (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .kill      (1'b0),
        .src_pc    (pc_x),
        .src_inst  (inst_x),
        .src_valid (x_valid),
        .pc        (pc_mw),
        .inst      (inst_mw),
        .valid     (mw_valid)
    );

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: directed scenarios then random traffic, all checked
// against a slot-level behavioural model of the fetch pipeline.
module tb_fetch_pipe;
    import riscv_core_pkg::*;

    localparam logic [31:0] RPC = 32'h1000_0000;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] jal_target;
    logic [31:0] alu_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout = 32'd0;
    logic [31:0] pc_fd, inst_fd, pc_x, inst_x, pc_mw, inst_mw, instret;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          valid;
    } slot_t;

    bit          m_run;
    logic [31:0] m_pc;
    slot_t       m_x, m_mw;
    logic [31:0] m_instret;

    fetch_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .jal_target (jal_target),
        .alu_target (alu_target),
        .imem_addr  (imem_addr),
        .imem_dout  (imem_dout),
        .pc_fd      (pc_fd),
        .inst_fd    (inst_fd),
        .pc_x       (pc_x),
        .inst_x     (inst_x),
        .pc_mw      (pc_mw),
        .inst_mw    (inst_mw),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 | {16'h0000, a[15:0]};
    endfunction

    always @(posedge clk) imem_dout <= mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] jt,
                                                 input logic [31:0] at);
        if (sel == PCSEL_JAL) return jt;
        if (sel == PCSEL_ALU) return at;
        return m_pc + 32'd4;
    endfunction

    // One clock: apply inputs, check every output, then advance the model.
    task automatic cycle(input logic r, input logic s, input logic [1:0] sel,
                         input logic [31:0] jt, input logic [31:0] at);
        logic [31:0] e_addr, e_inst;
        slot_t       fd;
        rst = r; stall = s; pc_sel = sel; jal_target = jt; alu_target = at;
        #2;
        if (r || !m_run) begin
            e_addr = RPC;
            e_inst = NOPW;
        end else begin
            e_addr = s ? m_pc : model_target(sel, jt, at);
            e_inst = mem_word(m_pc);
        end
        chk("imem_addr", imem_addr, e_addr);
        chk("inst_fd", inst_fd, e_inst);
        chk("pc_fd", pc_fd, m_pc);
        chk("pc_x", pc_x, m_x.pc);
        chk("inst_x", inst_x, m_x.inst);
        chk("pc_mw", pc_mw, m_mw.pc);
        chk("inst_mw", inst_mw, m_mw.inst);
        chk("instret", instret, m_instret);
        @(posedge clk);
        if (r) begin
            m_run = 1'b0; m_pc = RPC; m_instret = 32'd0;
            m_x = '{32'd0, NOPW, 1'b0};
            m_mw = '{32'd0, NOPW, 1'b0};
        end else if (!m_run) begin
            m_run = 1'b1;
            m_mw = m_x;
            m_x = '{m_pc, NOPW, 1'b0};
            m_pc = RPC;
        end else if (!s) begin
            if (m_mw.valid) m_instret = m_instret + 32'd1;
            m_mw = m_x;
            fd = '{m_pc, mem_word(m_pc), 1'b1};
            if (sel == PCSEL_ALU) fd = '{m_pc, NOPW, 1'b0};
            m_x = fd;
            m_pc = model_target(sel, jt, at);
        end
        @(negedge clk);
    endtask

    initial begin
        m_run = 1'b0; m_pc = RPC; m_instret = 32'd0;
        m_x = '{32'd0, NOPW, 1'b0};
        m_mw = '{32'd0, NOPW, 1'b0};
        rst = 1'b1; stall = 1'b0; pc_sel = PCSEL_PC4;
        jal_target = 32'd0; alu_target = 32'd0;
        @(negedge clk);
        // Power-up: model state is only trusted after the first reset edge.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        repeat (3) cycle(1'b1, 1'b0, PCSEL_PC4, 32'd0, 32'd0);
        repeat (10) cycle(1'b0, 1'b0, PCSEL_PC4, 32'd0, 32'd0);

        // JALR redirect kills the FD slot
        cycle(1'b0, 1'b0, PCSEL_ALU, 32'd0, 32'h1000_0100);
        repeat (4) cycle(1'b0, 1'b0, PCSEL_PC4, 32'd0, 32'd0);

        // JAL in FD: no bubble
        cycle(1'b0, 1'b0, PCSEL_JAL, 32'h1000_0040, 32'd0);
        repeat (3) cycle(1'b0, 1'b0, PCSEL_PC4, 32'd0, 32'd0);

        // Stall with a redirect request that must be ignored
        repeat (4) cycle(1'b0, 1'b1, PCSEL_ALU, 32'd0, 32'h1000_0200);
        repeat (3) cycle(1'b0, 1'b0, PCSEL_PC4, 32'd0, 32'd0);

        // PC wrap through the top of the address space
        cycle(1'b0, 1'b0, PCSEL_JAL, 32'hFFFF_FFFC, 32'd0);
        repeat (3) cycle(1'b0, 1'b0, PCSEL_PC4, 32'd0, 32'd0);

        // Reset arriving on a redirect cycle wins
        cycle(1'b1, 1'b1, PCSEL_ALU, 32'd0, 32'h1000_0300);
        repeat (6) cycle(1'b0, 1'b0, 2'd3, 32'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic r, s;
            logic [1:0] sel;
            logic [31:0] jt, at;
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 4) == 0);
            sel = 2'($urandom_range(0, 3));
            jt  = {16'h1000, 16'($urandom) & 16'hFFFC};
            at  = {16'h1000, 16'($urandom) & 16'hFFFC};
            cycle(r, s, sel, jt, at);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1000_0000: address of the first fetch after reset.
REQ-002 SHALL have parameter NOP, default 32'h0000_0013 (addi x0,x0,0): bubble encoding.
REQ-003 SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port stall, input, 1: hold the PC and all stage registers.
REQ-006 SHALL have port pc_sel, input, 2: 0 = JAL target, 1 = ALU target, 2 or 3 = PC+4.
REQ-007 SHALL have port jal_target, input, 32: PC+imm for a JAL in FD.
REQ-008 SHALL have port alu_target, input, 32: JALR or taken-branch target resolved in X.
REQ-009 SHALL have port imem_addr, output, 32: synchronous-read instruction BRAM address, sampled at the clock edge.
REQ-010 SHALL have port imem_dout, input, 32: BRAM data for the address sampled at the previous edge.
REQ-011 SHALL have ports pc_fd and inst_fd, output, 32 each: FD-stage PC and instruction.
REQ-012 SHALL have ports pc_x and inst_x, output, 32 each: X-stage PC and instruction.
REQ-013 SHALL have ports pc_mw and inst_mw, output, 32 each: MW-stage PC and instruction.
REQ-014 SHALL have port instret, output, 32: count of retired non-bubble instructions.

Function
REQ-015 SHALL have a 2-state FSM {BOOT, RUN}. rst forces BOOT. BOOT moves to RUN unconditionally after one non-reset cycle. RUN stays in RUN until rst.
REQ-016 In BOOT, imem_addr SHALL be RESET_PC, inst_fd SHALL be NOP with fd_valid=0, and pc_fd SHALL load RESET_PC.
REQ-017 In RUN with stall=0, imem_addr SHALL be next_pc, defined by pc_sel:
- pc_sel=0: jal_target
- pc_sel=1: alu_target
- otherwise: pc_fd+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0)
REQ-018 In RUN with stall=0, pc_fd SHALL load next_pc at the edge. inst_fd SHALL show imem_dout combinationally, i.e. zero-cycle latency from the BRAM output.
REQ-019 With stall=1, imem_addr SHALL be pc_fd so the BRAM re-reads. pc_fd, all X/MW registers, valid bits and instret SHALL hold. pc_sel SHALL be ignored.
REQ-020 The FD-to-X advance SHALL copy pc_fd/inst_fd/fd_valid. When pc_sel=1, X SHALL instead load inst_x=NOP, valid=0 (kill the wrong-path FD instruction).
REQ-021 pc_sel=0 SHALL NOT kill any stage; the JAL advances to X normally.
REQ-022 The X-to-MW advance SHALL copy pc_x/inst_x/x_valid every non-stalled edge, including a redirect edge.
REQ-023 instret SHALL increment by 1 on each non-stalled edge where mw_valid=1, wrapping modulo 2^32.
REQ-024 Bubble PC fields SHALL carry the PC of the killed slot. Bubbles never count toward instret.

Reset
REQ-025 While rst=1 at an edge, the block SHALL load:
- state=BOOT, pc_fd=RESET_PC
- pc_x=pc_mw=0, inst_x=inst_mw=NOP
- all valid bits=0, instret=0
REQ-026 While rst=1, imem_addr SHALL be RESET_PC and inst_fd SHALL be NOP.
REQ-027 rst SHALL take priority over stall and pc_sel. Reset mid-stream SHALL discard all in-flight instructions.

Structure
REQ-028 RESET_PC default, NOP, the pc_sel encodings (PCSEL_JAL=0, PCSEL_ALU=1, PCSEL_PC4=2) and the FSM state encoding SHALL live in the shared core package (riscv_core_pkg). control logic SHALL use the same pc_sel constants.
REQ-029 A sub-module, pipe_stage_reg, SHALL implement one stage register (pc, inst, valid, with load/hold/kill) and SHALL be instantiated twice: X and MW.

Verification
REQ-030 Reset sequence: rst high 3 cycles, then low, with imem model returning 32'hAAAA_0000|addr[15:0]. Required:
- imem_addr = 32'h1000_0000, 32'h1000_0000, 32'h1000_0004, ...
- first cycle inst_fd = NOP
- instret reaches 1 exactly 3 edges after the first valid FD instruction
REQ-031 Straight-line run, pc_sel=2 for 10 cycles: pc_fd steps by 4; pc_x and pc_mw trail by 1 and 2 cycles; instret increments once per cycle once MW is filled.
REQ-032 JALR redirect: pc_sel=1, alu_target=32'h1000_0100 while inst_x is JALR. Required:
- imem_addr = 32'h1000_0100 that cycle
- next cycle inst_x = NOP, pc_fd = 32'h1000_0100
- instret skips exactly one count
REQ-033 JAL in FD: pc_sel=0, jal_target=32'h1000_0040. Required: next cycle pc_fd = 32'h1000_0040, inst_x = the JAL word, no bubble inserted.
REQ-034 Stall: stall=1 for 4 cycles, with pc_sel=1 asserted during the stall. Required:
- all outputs constant
- imem_addr = pc_fd throughout
- pc_sel ignored
- after release, advance resumes from the held state
REQ-035 Wrap and mid-run reset:
- force pc_fd = 32'hFFFF_FFFC with pc_sel=2: next pc_fd = 0
- assert rst during a redirect cycle: reset values per REQ-025 on the next edge
